axi_decerr_slave: RTL and testbench



---
 rtl/axi_decerr_slave_pkg.sv | 19 +
 rtl/axi_decerr_slave_if.sv | 50 +++++
 rtl/axi_decerr_rd.sv | 69 ++++++
 rtl/axi_decerr_slave.sv | 71 +++++++
 tb/tb_axi_decerr_slave.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_decerr_slave_pkg.sv
// Shared constants and FSM state types for the DECERR terminating slave.
// Both channel FSMs import this package.
package axi_decerr_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi_decerr_slave_if.sv
// AXI4 signal subset used by the DECERR slave. Fields that the slave ignores
// (address, size, burst, write data, strobes, ...) are left out.
interface axi_decerr_slave_if #(
    parameter int ID_WIDTH   = 10,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
);

    logic [ID_WIDTH-1:0]   aw_id;
    logic                  aw_valid;
    logic                  aw_ready;

    logic                  w_last;
    logic                  w_valid;
    logic                  w_ready;

    logic [ID_WIDTH-1:0]   b_id;
    logic [1:0]            b_resp;
    logic [USER_WIDTH-1:0] b_user;
    logic                  b_valid;
    logic                  b_ready;

    logic [ID_WIDTH-1:0]   ar_id;
    logic [7:0]            ar_len;
    logic                  ar_valid;
    logic                  ar_ready;

    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_user;
    logic                  r_valid;
    logic                  r_ready;

    modport slave (
        input  aw_id, aw_valid, w_last, w_valid, b_ready,
               ar_id, ar_len, ar_valid, r_ready,
        output aw_ready, w_ready, b_id, b_resp, b_user, b_valid,
               ar_ready, r_id, r_data, r_resp, r_last, r_user, r_valid
    );

    modport master (
        output aw_id, aw_valid, w_last, w_valid, b_ready,
               ar_id, ar_len, ar_valid, r_ready,
        input  aw_ready, w_ready, b_id, b_resp, b_user, b_valid,
               ar_ready, r_id, r_data, r_resp, r_last, r_user, r_valid
    );

endinterface

// File: rtl/axi_decerr_rd.sv
// Read channel of the DECERR slave: accepts one AR at a time and returns
// ar_len+1 DECERR beats carrying a constant data pattern.
module axi_decerr_rd
    import axi_decerr_slave_pkg::*;
#(
    parameter int          ID_WIDTH   = 10,
    parameter int          DATA_WIDTH = 64,
    parameter int          USER_WIDTH = 1,
    parameter logic [63:0] RESP_DATA  = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ID_WIDTH-1:0]   ar_id,
    input  logic [7:0]            ar_len,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    output logic [ID_WIDTH-1:0]   r_id,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [1:0]            r_resp,
    output logic                  r_last,
    output logic [USER_WIDTH-1:0] r_user,
    output logic                  r_valid,
    input  logic                  r_ready
);

    r_state_e            state_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= R_IDLE;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                R_IDLE: begin
                    if (ar_valid) begin
                        state_q <= R_DATA;
                        id_q    <= ar_id;
                        len_q   <= ar_len;
                        cnt_q   <= '0;
                    end
                end
                R_DATA: begin
                    if (r_ready) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (r_last) state_q <= R_IDLE;
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    // r_last compares before the increment, so a 256-beat burst ends at cnt=255.
    assign ar_ready = (state_q == R_IDLE);
    assign r_valid  = (state_q == R_DATA);
    assign r_last   = (state_q == R_DATA) && (cnt_q == len_q);
    assign r_id     = id_q;
    assign r_data   = DATA_WIDTH'(RESP_DATA);
    assign r_resp   = RESP_DECERR;
    assign r_user   = '0;

endmodule

// File: rtl/axi_decerr_slave.sv
// Terminating AXI4 slave: completes every write and read with DECERR so that
// accesses to unmapped space never stall the interconnect.
module axi_decerr_slave
    import axi_decerr_slave_pkg::*;
#(
    parameter int          ID_WIDTH   = 10,
    parameter int          DATA_WIDTH = 64,
    parameter int          USER_WIDTH = 1,
    parameter logic [63:0] RESP_DATA  = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    axi_decerr_slave_if.slave  bus
);

    w_state_e            w_state_q;
    w_state_e            w_state_d;
    logic [ID_WIDTH-1:0] b_id_q;

    // NOTE: the next-state value is defaulted first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE:  if (bus.aw_valid)                w_state_d = W_DATA;
            W_DATA:  if (bus.w_valid && bus.w_last)   w_state_d = W_RESP;
            W_RESP:  if (bus.b_ready)                 w_state_d = W_IDLE;
            default:                                  w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            b_id_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            if (w_state_q == W_IDLE && bus.aw_valid) b_id_q <= bus.aw_id;
        end
    end

    // Write data is held off until the address has been taken.
    assign bus.aw_ready = (w_state_q == W_IDLE);
    assign bus.w_ready  = (w_state_q == W_DATA);
    assign bus.b_valid  = (w_state_q == W_RESP);
    assign bus.b_id     = b_id_q;
    assign bus.b_resp   = RESP_DECERR;
    assign bus.b_user   = '0;

    axi_decerr_rd #(
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .USER_WIDTH (USER_WIDTH),
        .RESP_DATA  (RESP_DATA)
    ) u_rd (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .ar_id    (bus.ar_id),
        .ar_len   (bus.ar_len),
        .ar_valid (bus.ar_valid),
        .ar_ready (bus.ar_ready),
        .r_id     (bus.r_id),
        .r_data   (bus.r_data),
        .r_resp   (bus.r_resp),
        .r_last   (bus.r_last),
        .r_user   (bus.r_user),
        .r_valid  (bus.r_valid),
        .r_ready  (bus.r_ready)
    );

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Scoreboard bench for axi_decerr_slave: inputs change on the falling edge,
// monitors sample 1 time unit later and compare B/R against expected queues.
module tb_axi_decerr_slave;

    localparam int          ID_W   = 10;
    localparam int          DATA_W = 64;
    localparam logic [63:0] EXP_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            last;
    } rbeat_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;

    axi_decerr_slave_if #(.ID_WIDTH(ID_W), .DATA_WIDTH(DATA_W), .USER_WIDTH(1)) bus ();

    axi_decerr_slave #(
        .ID_WIDTH   (ID_W),
        .DATA_WIDTH (DATA_W),
        .USER_WIDTH (1),
        .RESP_DATA  (EXP_DATA)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int r_hs  = 0;
    int b_hs  = 0;

    rbeat_t          rq[$];
    logic [ID_W-1:0] bq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // R channel scoreboard: every valid cycle must match the head beat.
    always @(negedge clk) begin
        #1;
        if (rst_ni && bus.r_valid) begin
            if (rq.size() == 0) begin
                check("r_unexpected", 1, 0);
            end else begin
                check("r_id",   bus.r_id,   rq[0].id);
                check("r_last", bus.r_last, rq[0].last);
                check("r_resp", bus.r_resp, 2'b11);
                check("r_data", bus.r_data, EXP_DATA);
                check("r_user", bus.r_user, 0);
                if (bus.r_ready) begin
                    void'(rq.pop_front());
                    r_hs++;
                end
            end
        end
    end

    // B channel scoreboard.
    always @(negedge clk) begin
        #1;
        if (rst_ni && bus.b_valid) begin
            if (bq.size() == 0) begin
                check("b_unexpected", 1, 0);
            end else begin
                check("b_id",   bus.b_id,   bq[0]);
                check("b_resp", bus.b_resp, 2'b11);
                check("b_user", bus.b_user, 0);
                if (bus.b_ready) begin
                    void'(bq.pop_front());
                    b_hs++;
                end
            end
        end
    end

    // All send tasks are entered on a falling edge and return on one.
    task automatic send_aw(input logic [ID_W-1:0] id);
        bit ok = 1'b0;
        bus.aw_id    = id;
        bus.aw_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            #1;
            ok = bus.aw_ready;
            if (ok) bq.push_back(id);
            @(negedge clk);
        end
        if (!ok) check("aw_timeout", 0, 1);
        bus.aw_valid = 1'b0;
    endtask

    task automatic send_w(input int beats);
        for (int i = 0; i < beats; i++) begin
            bit ok = 1'b0;
            bus.w_valid = 1'b1;
            bus.w_last  = (i == beats - 1);
            for (int t = 0; t < 50 && !ok; t++) begin
                #1;
                ok = bus.w_ready;
                @(negedge clk);
            end
            if (!ok) check("w_timeout", 0, 1);
        end
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
    endtask

    task automatic push_read(input logic [ID_W-1:0] id, input int len);
        for (int i = 0; i <= len; i++) rq.push_back('{id: id, last: (i == len)});
    endtask

    task automatic send_ar(input logic [ID_W-1:0] id, input int len);
        bit ok = 1'b0;
        bus.ar_id    = id;
        bus.ar_len   = 8'(len);
        bus.ar_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            #1;
            ok = bus.ar_ready;
            if (ok) push_read(id, len);
            @(negedge clk);
        end
        if (!ok) check("ar_timeout", 0, 1);
        bus.ar_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc, input bit rnd, input bit wait_b);
        for (int t = 0; t < max_cyc; t++) begin
            if (rq.size() == 0 && (!wait_b || bq.size() == 0)) return;
            bus.r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
        end
        check("drain_timeout", rq.size() + (wait_b ? bq.size() : 0), 0);
    endtask

    initial begin
        int r0;
        int b0;
        bus.aw_id = '0; bus.aw_valid = 1'b0;
        bus.w_last = 1'b0; bus.w_valid = 1'b0;
        bus.b_ready = 1'b1;
        bus.ar_id = '0; bus.ar_len = '0; bus.ar_valid = 1'b0;
        bus.r_ready = 1'b1;

        // Reset values
        #2;
        check("rst_aw_ready", bus.aw_ready, 1);
        check("rst_ar_ready", bus.ar_ready, 1);
        check("rst_w_ready",  bus.w_ready,  0);
        check("rst_b_valid",  bus.b_valid,  0);
        check("rst_r_valid",  bus.r_valid,  0);
        check("rst_r_last",   bus.r_last,   0);
        check("rst_b_id",     bus.b_id,     0);
        check("rst_r_id",     bus.r_id,     0);
        check("rst_b_resp",   bus.b_resp,   2'b11);
        check("rst_r_resp",   bus.r_resp,   2'b11);
        check("rst_r_data",   bus.r_data,   EXP_DATA);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // Single write, B held for one cycle to observe aw_ready
        send_aw(10'h15);
        #1;
        check("t1_aw_ready_data", bus.aw_ready, 0);
        check("t1_w_ready",       bus.w_ready,  1);
        @(negedge clk);
        bus.b_ready = 1'b0;
        send_w(1);
        #1;
        check("t1_b_valid",       bus.b_valid,  1);
        check("t1_aw_ready_resp", bus.aw_ready, 0);
        @(negedge clk);
        bus.b_ready = 1'b1;
        @(negedge clk);
        #1;
        check("t1_b_done",      bus.b_valid,  0);
        check("t1_aw_ready_ok", bus.aw_ready, 1);
        check("t1_bq_empty",    bq.size(),    0);
        @(negedge clk);

        // W before AW, 4-beat burst
        b0 = b_hs;
        bus.w_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_w_held", bus.w_ready, 0);
            @(negedge clk);
        end
        send_aw(10'h0C);
        send_w(4);
        drain(50, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("t2_b_count", b_hs - b0, 1);

        // 4-beat read at full throughput
        r0 = r_hs;
        send_ar(10'h2A, 3);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_r_valid", bus.r_valid, 1);
            @(negedge clk);
        end
        #1;
        check("t3_r_idle", bus.r_valid, 0);
        check("t3_count",  r_hs - r0,   4);
        @(negedge clk);

        // 256-beat read with random backpressure
        r0 = r_hs;
        send_ar(10'h133, 255);
        drain(4000, 1'b1, 1'b0);
        bus.r_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_count", r_hs - r0, 256);

        // Simultaneous AW and AR, B stalled while the read completes
        r0 = r_hs;
        bus.b_ready  = 1'b0;
        bus.aw_id    = 10'h011;
        bus.aw_valid = 1'b1;
        bus.ar_id    = 10'h022;
        bus.ar_len   = 8'd2;
        bus.ar_valid = 1'b1;
        #1;
        check("t5_aw_ready", bus.aw_ready, 1);
        check("t5_ar_ready", bus.ar_ready, 1);
        if (bus.aw_ready) bq.push_back(10'h011);
        if (bus.ar_ready) push_read(10'h022, 2);
        @(negedge clk);
        bus.aw_valid = 1'b0;
        bus.ar_valid = 1'b0;
        send_w(1);
        drain(20, 1'b0, 1'b0);
        check("t5_r_count", r_hs - r0, 3);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_b_stalled", bus.b_valid, 1);
            @(negedge clk);
        end
        bus.b_ready = 1'b1;
        drain(20, 1'b0, 1'b1);

        // Reset during beat 2 of an 8-beat read
        send_ar(10'h007, 7);
        repeat (2) @(negedge clk);
        #2;
        rst_ni = 1'b0;
        rq.delete();
        bq.delete();
        #1;
        check("t6_r_valid", bus.r_valid,  0);
        check("t6_r_last",  bus.r_last,   0);
        check("t6_ar_rdy",  bus.ar_ready, 1);
        check("t6_aw_rdy",  bus.aw_ready, 1);
        check("t6_r_id",    bus.r_id,     0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        r0 = r_hs;
        send_ar(10'h009, 2);
        drain(20, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("t6_count", r_hs - r0, 3);
        check("end_rq_empty", rq.size(), 0);
        check("end_bq_empty", bq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
